// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, UART byte width, MMIO map.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int UART_DW = 8;

  localparam logic [31:0] UART_ADDR_CTRL   = 32'h8000_0000;
  localparam logic [31:0] UART_ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] UART_ADDR_TXDATA = 32'h8000_0008;
  localparam logic [31:0] UART_ADDR_RXDATA = 32'h8000_000C;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo N.
module uart_tx_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART transmitter, with stall-timeout release
// and a single registered output stage.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int HOLD_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [N_REQ-1:0]     ReqValid,
  input  logic [8*N_REQ-1:0]   ReqData,
  input  logic [N_REQ-1:0]     ReqLast,
  output logic [N_REQ-1:0]     ReqReady,
  output logic [N_REQ-1:0]     Grant,
  output logic [UART_DW-1:0]   DataIn,
  output logic                 DataInValid,
  input  logic                 DataInReady,
  output logic                 Busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(HOLD_TIMEOUT);

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [TO_W-1:0]      stall_q, stall_d;
  logic [UART_DW-1:0]   data_q, data_d;
  logic                 dvld_q, dvld_d;

  logic [N_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 own_vld, own_last, out_free, xfer, timeout;
  logic [UART_DW-1:0]   own_dat;
  logic [IDX_W-1:0]     ptr_adv;

  uart_tx_arbiter_rr_pick #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_pick (
    .req (ReqValid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_vld  = ReqValid[owner_q];
  assign own_last = ReqLast[owner_q];
  assign own_dat  = ReqData[{owner_q, 3'b000} +: UART_DW];
  assign out_free = !dvld_q || DataInReady;
  assign xfer     = (state_q == ST_LOCKED) && own_vld && out_free;
  // A transfer in the timeout cycle (Last or not) keeps the owner; Last then releases normally.
  assign timeout  = (HOLD_TIMEOUT != 0) && (state_q == ST_LOCKED) && (stall_q == TO_LIMIT) && !xfer;
  assign ptr_adv  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  assign ReqReady    = ((state_q == ST_LOCKED) && out_free) ? grant_q : '0;
  assign Grant       = grant_q;
  assign DataIn      = data_q;
  assign DataInValid = dvld_q;
  assign Busy        = (state_q == ST_LOCKED) || dvld_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCKED;
          grant_d = pick_gnt;
          owner_d = pick_idx;
          stall_d = '0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          stall_d = '0;
        end else if (!own_vld && (stall_q != '1)) begin
          stall_d = stall_q + TO_W'(1);
        end
        if ((xfer && own_last) || timeout) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_adv;
          stall_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output stage: refill on transfer, otherwise drain when the UART takes the byte.
  always_comb begin
    data_d = data_q;
    dvld_d = dvld_q;
    if (xfer) begin
      data_d = own_dat;
      dvld_d = 1'b1;
    end else if (DataInReady) begin
      dvld_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      data_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      data_q  <= data_d;
      dvld_q  <= dvld_d;
    end
  end

endmodule
